md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Sequences the multiply/divide unit and owns the HI/LO registers for the 5-stage MIPS pipeline.
- It accepts mult/multu/div/divu/mthi/mtlo from the E stage and models the multi-cycle latency with a busy counter.
- It raises a stall request to the hazard unit whenever a D-stage HI/LO-related instruction would conflict with an in-flight operation.
- It sits beside the ALU in E and drives HI/LO to the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  E-stage instruction is a valid mult/multu/div/divu/mthi/mtlo this cycle.
- md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; other codes are treated as no-op.
- a  input  32  rs operand (E stage, forwarded).
- b  input  32  rt operand (E stage, forwarded).
- d_uses_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  a mult/div is in flight.
- md_stall  output  1  stall request to the hazard unit (freezes PC/F/D, bubbles E).
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, count=0, pending_hi/pending_lo=0; busy=0 and md_stall=0 follow combinationally.
- States are implied by count: IDLE (count==0) and RUN (count>0).
- busy = (count != 0).
- md_stall = d_uses_md & (busy | (start & md_op is mult/multu/div/divu)).
- Accepting a mult/div (IDLE, start=1, md_op ∈ {000..011}), at that edge:
  - compute the full result into pending_hi/pending_lo;
  - count <= MULT_CYCLES or DIV_CYCLES.
- Result formats:
  - mult: signed 32x32 → 64-bit product; pending_hi = bits [63:32], pending_lo = bits [31:0].
  - multu: same split, operands unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend a.
  - divu: unsigned quotient and remainder.
  - div with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (b==0, div or divu): the operation still occupies DIV_CYCLES, but hi/lo are left unchanged at commit.
- RUN: count decrements by 1 each rising edge.
  - On the edge where count goes 1→0, hi<=pending_hi and lo<=pending_lo (suppressed for divide-by-zero).
  - Latency: accepted at edge T, busy high cycles T+1..T+N, new hi/lo visible from the cycle after edge T+N.
- mthi/mtlo (start=1, md_op 100/101) in IDLE: hi<=a or lo<=a at that edge; busy is not affected.
- start while busy=1: ignored; no state change, no hi/lo write.
  - md_stall normally prevents this; the bench checks it as a protection case.
- A mult/div start arriving in the same cycle as count 1→0 is treated as busy and ignored. The pipeline cannot issue it because D was stalled.
- mfhi/mflo read hi/lo combinationally. They are stalled by md_stall while busy, so a stale value is never read.
- reset asserted mid-operation: count is cleared immediately, the pending result is discarded, hi/lo go to 0.
- Undefined md_op codes (110, 111) with start=1: no-op.

Test Plan:
- Reset, then mult a=0xFFFFFFFE (-2), b=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2 → busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu a=7, b=0 after mtlo a=0x1234 → lo stays 0x1234 after 10 busy cycles, hi unchanged.
- mult issued with d_uses_md=1 held throughout:
  - md_stall=1 in the start cycle and all 5 busy cycles, then 0;
  - a second start pulsed during busy leaves hi/lo and count unaffected.
- div in flight, reset pulsed low at cycle 4 → busy=0, hi=lo=0 immediately; no commit afterwards.

Source files
------------

// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//
// Sequences the multiply/divide unit of the 5-stage MIPS pipeline and owns
// the architectural HI/LO registers. A mult/div accepted in E computes its
// full result into a pending buffer at once. A busy counter then models the
// multi-cycle latency, and the buffer is committed to HI/LO when the counter
// runs out. While an operation is in flight, any HI/LO-related instruction
// in D gets a stall request so that nobody can observe a stale HI/LO.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous active-low reset (0 = reset)
//   start      in   1   E-stage instruction is a valid md operation
//   md_op      in   3   000 mult, 001 multu, 010 div, 011 divu,
//                       100 mthi, 101 mtlo, others no-op
//   a          in  32   rs operand (forwarded)
//   b          in  32   rt operand (forwarded)
//   d_uses_md  in   1   D-stage instruction touches the md unit or HI/LO
//   busy       out  1   a mult/div is in flight
//   md_stall   out  1   stall request to the hazard unit
//   hi         out 32   architectural HI
//   lo         out 32   architectural LO
// ---------------------------------------------------------------------------
module md_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        d_uses_md,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic [CW-1:0] count;
   logic [31:0]   pending_hi;
   logic [31:0]   pending_lo;
   logic          pending_dz;

   logic [63:0]   prod_s;
   logic [63:0]   prod_u;
   logic          div_signed;
   logic [31:0]   a_mag;
   logic [31:0]   b_mag;
   logic [31:0]   div_n;
   logic [31:0]   div_d;
   logic [31:0]   safe_d;
   logic [31:0]   uq;
   logic [31:0]   ur;
   logic [31:0]   div_q;
   logic [31:0]   div_r;

   assign busy     = (count != '0);
   assign md_stall = d_uses_md & (busy | (start & ~md_op[2]));

   // Result datapath. The signed product comes from sign-extending both
   // operands to 64 bits: the low 64 bits of that product are the signed
   // result. Signed division works on magnitudes and re-applies the signs
   // afterwards. This also gives the defined answer for 0x80000000 / -1
   // (quotient 0x80000000, remainder 0). A zero divisor is swapped for 1 so
   // the divider never sees it; that result is discarded at commit anyway.
   always_comb begin
      prod_s     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u     = {32'b0, a} * {32'b0, b};
      div_signed = (md_op == OP_DIV);
      a_mag      = a[31] ? (~a + 32'd1) : a;
      b_mag      = b[31] ? (~b + 32'd1) : b;
      div_n      = div_signed ? a_mag : a;
      div_d      = div_signed ? b_mag : b;
      safe_d     = (div_d == 32'd0) ? 32'd1 : div_d;
      uq         = div_n / safe_d;
      ur         = div_n % safe_d;
      div_q      = (div_signed & (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
      div_r      = (div_signed & a[31]) ? (~ur + 32'd1) : ur;
   end

   // Sequencer. While busy, starts are ignored and the counter drains. The
   // pending result commits on the 1->0 step unless it was a divide by zero.
   // When idle, a mult/div loads the pending buffer and the counter, and
   // mthi/mtlo write HI/LO directly without going busy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count      <= '0;
         pending_hi <= 32'd0;
         pending_lo <= 32'd0;
         pending_dz <= 1'b0;
         hi         <= 32'd0;
         lo         <= 32'd0;
      end else if (busy) begin
         count <= count - CNT_ONE;
         if (count == CNT_ONE && !pending_dz) begin
            hi <= pending_hi;
            lo <= pending_lo;
         end
      end else if (start) begin
         case (md_op)
            OP_MULT: begin
               pending_hi <= prod_s[63:32];
               pending_lo <= prod_s[31:0];
               pending_dz <= 1'b0;
               count      <= MULT_CNT;
            end
            OP_MULTU: begin
               pending_hi <= prod_u[63:32];
               pending_lo <= prod_u[31:0];
               pending_dz <= 1'b0;
               count      <= MULT_CNT;
            end
            OP_DIV, OP_DIVU: begin
               pending_hi <= div_r;
               pending_lo <= div_q;
               pending_dz <= (b == 32'd0);
               count      <= DIV_CNT;
            end
            OP_MTHI: hi <= a;
            OP_MTLO: lo <= a;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
//
// Directed bench for md_sequencer. The stimulus pushes a hand-computed
// {hi, lo, busy length} entry for each mult/div it issues. A monitor samples
// on the falling clock edge and measures every busy window. When busy drops,
// it pops the oldest entry and compares the window length and HI/LO.
// Immediate effects such as reset, mthi/mtlo and stall are checked inline.
// ---------------------------------------------------------------------------
module tb_md_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_uses_md;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic prev_busy = 1'b0;
   int   run_len   = 0;

   md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .md_op     (md_op),
      .a         (a),
      .b         (b),
      .d_uses_md (d_uses_md),
      .busy      (busy),
      .md_stall  (md_stall),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison. Every check in the bench goes through here.
   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
      end
   endtask

   // Called at #1 after a rising edge. Drives one start for a single cycle
   // and returns at #1 after the edge that samples it.
   task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
      start = 1'b1;
      md_op = op;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input int n);
      exp_t e;
      e.hi     = h;
      e.lo     = l;
      e.cycles = n;
      sb.push_back(e);
   endtask

   // Waits until busy drops, with a cycle budget. Then waits past one more
   // falling edge so the monitor has a chance to score the window.
   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (busy) begin
         bad++;
         $display("[TB] FAIL %s: busy still high after %0d cycles", name, n);
      end
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // Monitor: measures each busy window on falling edges and scores it
   // against the oldest expected entry when busy drops.
   always @(negedge clk) begin
      exp_t e;
      if (busy) begin
         run_len++;
      end else if (prev_busy) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_commit: busy window of %0d cycles with nothing expected", run_len);
         end else begin
            total--;
            e = sb.pop_front();
            check_output("busy_cycles", 32'(run_len), 32'(e.cycles));
            check_output("commit_hi", hi, e.hi);
            check_output("commit_lo", lo, e.lo);
         end
         run_len = 0;
      end
      prev_busy = busy;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      md_op     = 3'b000;
      a         = 32'd0;
      b         = 32'd0;
      d_uses_md = 1'b0;

      // Reset state
      #1;
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_stall", 32'(md_stall), 32'd0);
      check_output("reset_hi", hi, 32'd0);
      check_output("reset_lo", lo, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // mult -2 * 3 = -6
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
      apply_stimulus(3'b000, 32'hFFFF_FFFE, 32'd3);
      wait_idle("mult_done");

      // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
      push_exp(32'h0000_0001, 32'hFFFF_FFFE, 5);
      apply_stimulus(3'b001, 32'hFFFF_FFFF, 32'd2);
      wait_idle("multu_done");

      // div -7 / 2: quotient -3, remainder -1
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      apply_stimulus(3'b010, 32'hFFFF_FFF9, 32'd2);
      wait_idle("div_done");

      // mtlo writes LO immediately and does not go busy
      apply_stimulus(3'b101, 32'h0000_1234, 32'd0);
      check_output("mtlo_lo", lo, 32'h0000_1234);
      check_output("mtlo_hi", hi, 32'hFFFF_FFFF);
      check_output("mtlo_busy", 32'(busy), 32'd0);

      // divu by zero: full latency, HI/LO left alone
      push_exp(32'hFFFF_FFFF, 32'h0000_1234, 10);
      apply_stimulus(3'b011, 32'd7, 32'd0);
      wait_idle("divu_zero_done");

      // Signed overflow divide: 0x80000000 / -1
      push_exp(32'h0000_0000, 32'h8000_0000, 10);
      apply_stimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle("div_ovf_done");

      // mthi
      apply_stimulus(3'b100, 32'h0000_CAFE, 32'd0);
      check_output("mthi_hi", hi, 32'h0000_CAFE);
      check_output("mthi_lo", lo, 32'h8000_0000);

      // mult 3*4 with d_uses_md held high. Two stray starts arrive during
      // busy, the second in the cycle where the count goes 1->0; both must
      // be ignored.
      push_exp(32'h0000_0000, 32'h0000_000C, 5);
      d_uses_md = 1'b1;
      start     = 1'b1;
      md_op     = 3'b000;
      a         = 32'd3;
      b         = 32'd4;
      #1;
      check_output("stall_start_cycle", 32'(md_stall), 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            start = 1'b1;
            md_op = 3'b000;
            a     = 32'd100;
            b     = 32'd100;
         end
         if (i == 4) begin
            start = 1'b1;
            md_op = 3'b100;
            a     = 32'h0000_DEAD;
         end
         check_output($sformatf("stall_busy_%0d", i), 32'(md_stall), 32'd1);
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      check_output("stall_released", 32'(md_stall), 32'd0);
      check_output("stall_busy_done", 32'(busy), 32'd0);
      d_uses_md = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;

      // Undefined opcode is a no-op
      apply_stimulus(3'b110, 32'h0000_0001, 32'd0);
      check_output("undef_hi", hi, 32'h0000_0000);
      check_output("undef_lo", lo, 32'h0000_000C);
      check_output("undef_busy", 32'(busy), 32'd0);

      // Reset in the middle of a divide. The monitor sees a 4-cycle window
      // that ends with HI/LO cleared.
      push_exp(32'h0000_0000, 32'h0000_0000, 4);
      apply_stimulus(3'b010, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_output("midreset_busy", 32'(busy), 32'd0);
      check_output("midreset_hi", hi, 32'd0);
      check_output("midreset_lo", lo, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check_output("post_reset_hi", hi, 32'd0);
      check_output("post_reset_lo", lo, 32'd0);
      check_output("post_reset_busy", 32'(busy), 32'd0);
      check_output("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
